// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: queue entry layout, instruction size, reset PC.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO of fetch entries with single-cycle flush; head is read from a register array.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  entry_t        entry_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic [CW-1:0] count_o
);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= entry_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC, credit-based requests to a 1-cycle instruction memory, and a decode-facing queue.
// Optional FETCH_BYPASS_EN forwards the memory response straight to decode when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned       XLEN     = XLEN_DEFAULT,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RESET_PC_DEFAULT),
    localparam int unsigned      CW       = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            im_req_o,
    output logic [XLEN-1:0] im_addr_o,
    input  logic [XLEN-1:0] im_dout_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic [CW-1:0]   count_o
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            inflight_q;

    logic [CW-1:0]   fifo_count;
    logic            fifo_valid;
    entry_t          fifo_head;
    entry_t          fifo_entry;
    logic            push;
    logic            pop;
    logic            bypass_take;

    assign fifo_valid = (fifo_count != '0);

    // Outstanding response counts against capacity; a same-cycle pop is deliberately not credited.
    assign im_req_o  = !redirect_i &&
                       ((CW+1)'(fifo_count) + (CW+1)'(inflight_q) < (CW+1)'(DEPTH));
    assign im_addr_o = pc_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= im_req_o;
            if (redirect_i) begin
                pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
            end else if (im_req_o) begin
                pc_q          <= pc_q + XLEN'(INST_BYTES);
                inflight_pc_q <= pc_q;
            end
        end
    end

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass = !fifo_valid && inflight_q && !redirect_i;

    always_comb begin
        inst_valid_o = fifo_valid && !redirect_i;
        inst_o       = fifo_head.inst;
        inst_pc_o    = fifo_head.pc;
        if (bypass) begin
            inst_valid_o = 1'b1;
            inst_o       = im_dout_i;
            inst_pc_o    = inflight_pc_q;
        end
    end

    assign bypass_take = bypass && inst_ready_i;
`else
    always_comb begin
        inst_valid_o = fifo_valid && !redirect_i;
        inst_o       = fifo_head.inst;
        inst_pc_o    = fifo_head.pc;
    end

    assign bypass_take = 1'b0;
`endif

    assign fifo_entry = '{pc: inflight_pc_q, inst: im_dout_i};
    assign push       = inflight_q && !redirect_i && !bypass_take;
    assign pop        = fifo_valid && inst_ready_i && !redirect_i;
    assign count_o    = fifo_count;

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .entry_i (fifo_entry),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

endmodule
